cpu_jtag_scan_master: RTL and testbench

CPU_JTAG_SCAN_MASTER -- requirements
Module: cpu_jtag_scan_master

---
 rtl/cpu_jtag_pkg.sv | 34 +++
 rtl/cpu_jtag_tck_gen.sv | 54 +++++
 rtl/cpu_jtag_scan_master.sv | 213 +++++++++++++++++++++
 tb/tb_cpu_jtag_scan_master.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_jtag_pkg.sv
// Shared state encoding, IR codes and widths for the virtual-JTAG scan master.
// Macro CPU_JTAG_SCAN_MASTER_RTI_EN adds the run-test-idle state to the encoding.
package cpu_jtag_pkg;

    localparam int DR_WIDTH_DEF = 38;
    localparam int LEN_W        = 6;
    localparam int IR_W         = 2;
    localparam int TCK_CNT_W    = 8;
    localparam int RTI_CNT_W    = 16;

    localparam logic [IR_W-1:0] IR_OCIMEM    = 2'd0;
    localparam logic [IR_W-1:0] IR_TRACEMEM  = 2'd1;
    localparam logic [IR_W-1:0] IR_BREAK     = 2'd2;
    localparam logic [IR_W-1:0] IR_TRACECTRL = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_UIR,
        ST_CDR,
        ST_SDR,
        ST_UDR,
        ST_RESP
`ifdef CPU_JTAG_SCAN_MASTER_RTI_EN
        , ST_RTI
`endif
    } scan_state_e;

    // A zero-length scan or one longer than the data register cannot be shifted.
    function automatic logic len_illegal(input logic [LEN_W-1:0] len,
                                         input int unsigned      max_len);
        return (len == '0) || (32'(len) > max_len);
    endfunction

endpackage

// File: rtl/cpu_jtag_tck_gen.sv
// Divides clk down to the virtual tck and emits one-clk enables in the cycle
// whose closing clk edge produces a tck rising or falling transition.
module cpu_jtag_tck_gen
    import cpu_jtag_pkg::*;
#(
    parameter int TCK_DIV = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic en_i,
    output logic vji_tck_o,
    output logic tck_rise_o,
    output logic tck_fall_o
);

    localparam logic [TCK_CNT_W-1:0] RELOAD = TCK_CNT_W'(TCK_DIV - 1);

    logic [TCK_CNT_W-1:0] cnt_q, cnt_d;
    logic                 tck_q, tck_d;
    logic                 tc;

    assign tc = (cnt_q == '0);

    // While disabled, tck parks low with a full half-period preloaded so the
    // first half-period after enable is exactly TCK_DIV clks long.
    always_comb begin
        cnt_d = cnt_q;
        tck_d = tck_q;
        if (!en_i) begin
            cnt_d = RELOAD;
            tck_d = 1'b0;
        end else if (tc) begin
            cnt_d = RELOAD;
            tck_d = ~tck_q;
        end else begin
            cnt_d = cnt_q - TCK_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q <= '0;
            tck_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tck_q <= tck_d;
        end
    end

    assign vji_tck_o  = tck_q;
    assign tck_rise_o = en_i & tc & ~tck_q;
    assign tck_fall_o = en_i & tc & tck_q;

endmodule

// File: rtl/cpu_jtag_scan_master.sv
// Virtual-JTAG scan master: one command = UIR, CDR, SDR (cmd_len bits), UDR,
// optional RTI (macro CPU_JTAG_SCAN_MASTER_RTI_EN), then a held response.
//
// state | meaning
// IDLE  | waiting for a command, cmd_ready high
// UIR   | present latched IR on vji_ir_in, vji_uir high for one tck period
// CDR   | vji_cdr high for one tck period, vji_ir_out captured on tck rise
// SDR   | shift cmd_len bits: tdi updated on tck fall, tdo sampled on tck rise
// UDR   | vji_udr high for one tck period
// RTI   | vji_rti high for RTI_CYCLES tck periods (option only)
// RESP  | rsp_valid held until rsp_ready
module cpu_jtag_scan_master
    import cpu_jtag_pkg::*;
#(
    parameter int DR_WIDTH   = DR_WIDTH_DEF,
    parameter int TCK_DIV    = 2,
    parameter int RTI_CYCLES = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [IR_W-1:0]     cmd_ir,
    input  logic [DR_WIDTH-1:0] cmd_data,
    input  logic [LEN_W-1:0]    cmd_len,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DR_WIDTH-1:0] rsp_data,
    output logic [IR_W-1:0]     rsp_ir,
    output logic                rsp_err,
    output logic                vji_tck,
    output logic                vji_tdi,
    output logic                vji_uir,
    output logic                vji_cdr,
    output logic                vji_sdr,
    output logic                vji_udr,
    output logic                vji_rti,
    output logic [IR_W-1:0]     vji_ir_in,
    input  logic                vji_tdo,
    input  logic [IR_W-1:0]     vji_ir_out
);

    scan_state_e          state_q, state_d;
    logic                 ready_q, ready_d;
    logic [IR_W-1:0]      ir_in_q, ir_in_d;
    logic [DR_WIDTH-1:0]  data_q, data_d;
    logic [LEN_W-1:0]     len_q, len_d;
    logic [LEN_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [DR_WIDTH-1:0]  cap_q, cap_d;
    logic [IR_W-1:0]      rsp_ir_q, rsp_ir_d;
    logic                 rsp_err_q, rsp_err_d;
    logic [LEN_W-1:0]     cap_idx;
    logic                 tck_en, tck_rise, tck_fall;
    logic                 unused_ir;

    assign tck_en = (state_q != ST_IDLE) && (state_q != ST_RESP);

    cpu_jtag_tck_gen #(
        .TCK_DIV (TCK_DIV)
    ) u_tck_gen (
        .clk        (clk),
        .reset_n    (reset_n),
        .en_i       (tck_en),
        .vji_tck_o  (vji_tck),
        .tck_rise_o (tck_rise),
        .tck_fall_o (tck_fall)
    );

    // bit_cnt counts remaining bits, so the bit being sampled is len - remaining.
    assign cap_idx = len_q - bit_cnt_q;

`ifdef CPU_JTAG_SCAN_MASTER_RTI_EN
    localparam logic [RTI_CNT_W-1:0] RTI_LOAD = RTI_CNT_W'(RTI_CYCLES);
    logic [RTI_CNT_W-1:0] rti_cnt_q, rti_cnt_d;
`else
    logic unused_rti;
    assign unused_rti = ^RTI_CYCLES;
`endif

    always_comb begin
        state_d   = state_q;
        ir_in_d   = ir_in_q;
        data_d    = data_q;
        len_d     = len_q;
        bit_cnt_d = bit_cnt_q;
        cap_d     = cap_q;
        rsp_ir_d  = rsp_ir_q;
        rsp_err_d = rsp_err_q;
`ifdef CPU_JTAG_SCAN_MASTER_RTI_EN
        rti_cnt_d = rti_cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid && ready_q) begin
                    data_d    = cmd_data;
                    len_d     = cmd_len;
                    bit_cnt_d = cmd_len;
                    cap_d     = '0;
                    rsp_ir_d  = '0;
                    if (len_illegal(cmd_len, DR_WIDTH)) begin
                        rsp_err_d = 1'b1;
                        state_d   = ST_RESP;
                    end else begin
                        rsp_err_d = 1'b0;
                        ir_in_d   = cmd_ir;
                        state_d   = ST_UIR;
                    end
                end
            end
            ST_UIR: begin
                if (tck_fall) state_d = ST_CDR;
            end
            ST_CDR: begin
                if (tck_rise) rsp_ir_d = vji_ir_out;
                if (tck_fall) state_d = ST_SDR;
            end
            ST_SDR: begin
                if (tck_rise) begin
                    cap_d = cap_q | ({{(DR_WIDTH-1){1'b0}}, vji_tdo} << cap_idx);
                end
                if (tck_fall) begin
                    if (bit_cnt_q == LEN_W'(1)) begin
                        state_d = ST_UDR;
                    end else begin
                        bit_cnt_d = bit_cnt_q - LEN_W'(1);
                        data_d    = data_q >> 1;
                    end
                end
            end
            ST_UDR: begin
                if (tck_fall) begin
`ifdef CPU_JTAG_SCAN_MASTER_RTI_EN
                    if (RTI_CYCLES > 0) begin
                        state_d   = ST_RTI;
                        rti_cnt_d = RTI_LOAD;
                    end else begin
                        state_d   = ST_RESP;
                    end
`else
                    state_d = ST_RESP;
`endif
                end
            end
`ifdef CPU_JTAG_SCAN_MASTER_RTI_EN
            ST_RTI: begin
                if (tck_fall) begin
                    if (rti_cnt_q == RTI_CNT_W'(1)) begin
                        state_d = ST_RESP;
                    end else begin
                        rti_cnt_d = rti_cnt_q - RTI_CNT_W'(1);
                    end
                end
            end
`endif
            ST_RESP: begin
                if (rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        // Registered so cmd_ready stays low through reset and rises one edge later.
        ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            ready_q   <= 1'b0;
            ir_in_q   <= '0;
            data_q    <= '0;
            len_q     <= '0;
            bit_cnt_q <= '0;
            cap_q     <= '0;
            rsp_ir_q  <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ready_q   <= ready_d;
            ir_in_q   <= ir_in_d;
            data_q    <= data_d;
            len_q     <= len_d;
            bit_cnt_q <= bit_cnt_d;
            cap_q     <= cap_d;
            rsp_ir_q  <= rsp_ir_d;
            rsp_err_q <= rsp_err_d;
        end
    end

`ifdef CPU_JTAG_SCAN_MASTER_RTI_EN
    always_ff @(posedge clk) begin
        if (!reset_n) rti_cnt_q <= '0;
        else          rti_cnt_q <= rti_cnt_d;
    end
    assign vji_rti = (state_q == ST_RTI);
`else
    assign vji_rti = 1'b0;
`endif

    assign vji_uir   = (state_q == ST_UIR);
    assign vji_cdr   = (state_q == ST_CDR);
    assign vji_sdr   = (state_q == ST_SDR);
    assign vji_udr   = (state_q == ST_UDR);
    assign vji_tdi   = (state_q == ST_SDR) & data_q[0];
    assign vji_ir_in = ir_in_q;

    assign cmd_ready = ready_q;
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_data  = cap_q;
    assign rsp_ir    = rsp_ir_q;
    assign rsp_err   = rsp_err_q;

    assign unused_ir = ^{IR_OCIMEM, IR_TRACEMEM, IR_BREAK, IR_TRACECTRL};

endmodule

// File: tb/tb_cpu_jtag_scan_master.sv
// Randomized bench for cpu_jtag_scan_master against a transaction-level model.
module tb_cpu_jtag_scan_master;
    import cpu_jtag_pkg::*;

    localparam int DRW  = 38;
    localparam int TDIV = 2;
    localparam int RTIC = 4;
    localparam int P    = 2 * TDIV;
`ifdef CPU_JTAG_SCAN_MASTER_RTI_EN
    localparam int RTI_EXP = RTIC * P;
`else
    localparam int RTI_EXP = 0;
`endif

    logic           clk, reset_n;
    logic           cmd_valid, cmd_ready;
    logic [1:0]     cmd_ir;
    logic [DRW-1:0] cmd_data;
    logic [5:0]     cmd_len;
    logic           rsp_valid, rsp_ready;
    logic [DRW-1:0] rsp_data;
    logic [1:0]     rsp_ir;
    logic           rsp_err;
    logic           vji_tck, vji_tdi, vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti;
    logic [1:0]     vji_ir_in, vji_ir_out;
    logic           vji_tdo;

    int n_vec = 0, n_err = 0;

    // bench-side debug-module model
    logic        loopback;
    logic [63:0] tdo_vec;
    int          rise_base;
    int          rise_total = 0;
    logic        tdo_drv;
    bit          tdi_chk_en;
    bit          tdi_seen[$];
    int n_uir = 0, n_cdr = 0, n_sdr = 0, n_udr = 0, n_rti = 0;
    int n_multi = 0, n_tck_bad = 0, n_tdi_bad = 0;
    logic [1:0]  uir_ir;
    logic        tck_prev = 1'b0, tdi_prev = 1'b0;

    cpu_jtag_scan_master #(
        .DR_WIDTH   (DRW),
        .TCK_DIV    (TDIV),
        .RTI_CYCLES (RTIC)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_ir     (cmd_ir),
        .cmd_data   (cmd_data),
        .cmd_len    (cmd_len),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_ir     (rsp_ir),
        .rsp_err    (rsp_err),
        .vji_tck    (vji_tck),
        .vji_tdi    (vji_tdi),
        .vji_uir    (vji_uir),
        .vji_cdr    (vji_cdr),
        .vji_sdr    (vji_sdr),
        .vji_udr    (vji_udr),
        .vji_rti    (vji_rti),
        .vji_ir_in  (vji_ir_in),
        .vji_tdo    (vji_tdo),
        .vji_ir_out (vji_ir_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        int k;
        k = rise_total - rise_base;
        tdo_drv = (k >= 0 && k < 64) ? tdo_vec[k[5:0]] : 1'b0;
    end
    assign vji_tdo = loopback ? vji_tdi : tdo_drv;

    always @(negedge clk) begin
        if (vji_uir) begin
            n_uir  <= n_uir + 1;
            uir_ir <= vji_ir_in;
        end
        if (vji_cdr) n_cdr <= n_cdr + 1;
        if (vji_sdr) n_sdr <= n_sdr + 1;
        if (vji_udr) n_udr <= n_udr + 1;
        if (vji_rti) n_rti <= n_rti + 1;
        if ($countones({vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti}) > 1) n_multi <= n_multi + 1;
        if (vji_tck && !(vji_uir | vji_cdr | vji_sdr | vji_udr | vji_rti)) n_tck_bad <= n_tck_bad + 1;
        if (vji_sdr && vji_tck && !tck_prev) begin
            tdi_seen.push_back(vji_tdi);
            rise_total <= rise_total + 1;
        end
        if (tdi_chk_en && (vji_tdi != tdi_prev) && !(tck_prev && !vji_tck)) n_tdi_bad <= n_tdi_bad + 1;
        tck_prev <= vji_tck;
        tdi_prev <= vji_tdi;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] ir, input logic [DRW-1:0] data, input logic [5:0] len);
        cmd_ir    = ir;
        cmd_data  = data;
        cmd_len   = len;
        cmd_valid = 1'b1;
        cyc();
        cmd_valid = 1'b0;
        cmd_data  = DRW'({$urandom(), $urandom()});
        cmd_ir    = 2'($urandom_range(0, 3));
        cmd_len   = 6'($urandom_range(0, 63));
    endtask

    task automatic run_scan(input logic [1:0] ir, input logic [DRW-1:0] data, input logic [5:0] len,
                            input bit lb, input logic [63:0] tv, input logic [1:0] iro, input int hold);
        bit             bad;
        logic [DRW-1:0] exp_d, exp_tdi, got_tdi;
        int             base, s_uir, s_cdr, s_sdr, s_udr, s_rti;
        bad   = (len == 0) || (len > DRW);
        exp_d = '0;
        exp_tdi = '0;
        got_tdi = '0;
        if (!bad) begin
            for (int i = 0; i < int'(len); i++) begin
                exp_d[i]   = lb ? data[i] : tv[i];
                exp_tdi[i] = data[i];
            end
        end
        loopback   = lb;
        tdo_vec    = tv;
        vji_ir_out = iro;
        check("ready_idle", cmd_ready, 1);
        base = rise_total;
        rise_base = rise_total;
        s_uir = n_uir; s_cdr = n_cdr; s_sdr = n_sdr; s_udr = n_udr; s_rti = n_rti;
        issue(ir, data, len);
        check("ready_busy", cmd_ready, 0);
        for (int i = 0; i < 3000 && !rsp_valid; i++) cyc();
        check("rsp_valid", rsp_valid, 1);
        for (int h = 0; h < hold; h++) begin
            check("hold_valid", rsp_valid, 1);
            check("hold_data", rsp_data, exp_d);
            check("hold_tck", vji_tck, 0);
            check("hold_ready", cmd_ready, 0);
            cyc();
        end
        check("rsp_err", rsp_err, bad);
        check("rsp_data", rsp_data, exp_d);
        if (!bad) begin
            check("rsp_ir", rsp_ir, iro);
            check("uir_ir", uir_ir, ir);
            for (int i = 0; i < int'(len); i++)
                if (base + i < tdi_seen.size()) got_tdi[i] = tdi_seen[base + i];
            check("tdi_bits", got_tdi, exp_tdi);
        end
        check("uir_clks", n_uir - s_uir, bad ? 0 : P);
        check("cdr_clks", n_cdr - s_cdr, bad ? 0 : P);
        check("sdr_clks", n_sdr - s_sdr, bad ? 0 : int'(len) * P);
        check("udr_clks", n_udr - s_udr, bad ? 0 : P);
        check("rti_clks", n_rti - s_rti, bad ? 0 : RTI_EXP);
        rsp_ready = 1'b1;
        cyc();
        rsp_ready = 1'b0;
        check("post_valid", rsp_valid, 0);
        check("post_ready", cmd_ready, 1);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_vji"}, {vji_tck, vji_tdi, vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti, vji_ir_in}, 0);
        check({tag, "_rsp"}, {rsp_valid, rsp_data, rsp_ir, rsp_err, cmd_ready}, 0);
    endtask

    initial begin
        int             base, vcnt;
        logic [DRW-1:0] d;
        logic [5:0]     l;
        reset_n = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0;
        cmd_ir = '0; cmd_data = '0; cmd_len = '0;
        loopback = 1'b1; tdo_vec = '0; vji_ir_out = '0; rise_base = 0;
        tdi_chk_en = 1'b1;
        repeat (3) cyc();
        check_zero("reset");
        reset_n = 1'b1;
        cyc();
        check("ready_after_reset", cmd_ready, 1);

        run_scan(IR_BREAK, 38'h2A_5555_5555, 6'd38, 1'b1, 64'h0, 2'b01, 0);
        run_scan(IR_OCIMEM, '0, 6'd8, 1'b0, 64'h8D, 2'b10, 0);
        run_scan(IR_TRACEMEM, 38'h1, 6'd0, 1'b1, 64'h0, 2'b00, 0);
        run_scan(IR_TRACECTRL, 38'h3F_FFFF_FFFF, 6'd39, 1'b1, 64'h0, 2'b00, 0);
        run_scan(IR_TRACECTRL, 38'h3, 6'd1, 1'b0, 64'h1, 2'b11, 0);
        run_scan(IR_OCIMEM, 38'h15_A5A5_0F0F, 6'd38, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 2'b01, 20);

        for (int n = 0; n < 14; n++) begin
            d = DRW'({$urandom(), $urandom()});
            l = 6'($urandom_range(0, 45));
            run_scan(2'($urandom_range(0, 3)), d, l, 1'($urandom_range(0, 1)),
                     {$urandom(), $urandom()}, 2'($urandom_range(0, 3)), $urandom_range(0, 5));
        end

        // reset while shifting bit 10 of 38
        d = DRW'({$urandom(), $urandom()});
        loopback = 1'b1;
        base = rise_total;
        rise_base = rise_total;
        issue(IR_BREAK, d, 6'd38);
        for (int i = 0; i < 2000 && (rise_total - base) < 10; i++) cyc();
        check("reached_bit10", vji_sdr, 1);
        tdi_chk_en = 1'b0;
        reset_n = 1'b0;
        cyc();
        check_zero("midscan_reset");
        reset_n = 1'b1;
        cyc();
        check("ready_after_midscan", cmd_ready, 1);
        tdi_chk_en = 1'b1;
        vcnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (rsp_valid) vcnt++;
            cyc();
        end
        check("no_rsp_after_reset", vcnt, 0);
        run_scan(IR_BREAK, d, 6'd38, 1'b1, 64'h0, 2'b10, 2);

        check("strobe_onehot", n_multi, 0);
        check("tck_outside_scan", n_tck_bad, 0);
        check("tdi_off_fall", n_tdi_bad, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
